// File: rtl/fifo_sched_pkg.sv
// Shared types and index helpers for the round-robin queue scheduler.
package fifo_sched_pkg;

  typedef enum logic {SCHED_IDLE, SCHED_SERVE} sched_state_t;

  // Modulo increment; n need not be a power of two.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating priority encoder: first set request found scanning from start, wrapping modulo N.
module rr_priority_picker
  import fifo_sched_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] pick
);

  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 32'(start);
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
      idx = next_idx(idx, N);
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin drain of N request queues into one valid/ready consumer, with burst limit and per-queue enable.
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int unsigned N_QUEUES    = 4,
  parameter int unsigned DWIDTH      = 16,
  parameter int unsigned IDX_WIDTH   = $clog2(N_QUEUES),
  parameter int unsigned BURST_MAX   = 4,
  parameter int unsigned BURST_WIDTH = $clog2(BURST_MAX + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_QUEUES-1:0]          q_empty,
  input  logic [N_QUEUES*DWIDTH-1:0]   q_dout,
  output logic [N_QUEUES-1:0]          q_rd_en,
  input  logic [N_QUEUES-1:0]          cfg_enable,
  output logic [DWIDTH-1:0]            out_data,
  output logic [IDX_WIDTH-1:0]         out_src,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  sched_state_t           state, state_nxt;
  logic [IDX_WIDTH-1:0]   grant;
  logic [BURST_WIDTH-1:0] burst_cnt;

  logic [N_QUEUES-1:0]    eligible;
  logic                   any_elig;
  logic [IDX_WIDTH-1:0]   scan_start;
  logic [IDX_WIDTH-1:0]   rr_pick;
  logic [IDX_WIDTH-1:0]   pick;
  logic                   cont_burst;
  logic                   can_load;
  logic                   pop;
  logic [DWIDTH-1:0]      q_word [N_QUEUES];

  assign eligible   = ~q_empty & cfg_enable;
  assign can_load   = ~out_valid | out_ready;
  assign scan_start = IDX_WIDTH'(next_idx(32'(grant), N_QUEUES));
  assign cont_burst = (state == SCHED_SERVE) && eligible[grant] &&
                      (burst_cnt < BURST_WIDTH'(BURST_MAX));
  assign pick       = cont_burst ? grant : rr_pick;
  assign pop        = can_load & any_elig & ~rst;
  assign busy       = out_valid | any_elig;

  rr_priority_picker #(
    .N  (N_QUEUES),
    .IW (IDX_WIDTH)
  ) u_picker (
    .req   (eligible),
    .start (scan_start),
    .found (any_elig),
    .pick  (rr_pick)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_QUEUES; i++) begin
      q_word[i] = q_dout[i*DWIDTH +: DWIDTH];
    end
  end

  always_comb begin
    q_rd_en = '0;
    if (pop) begin
      q_rd_en[pick] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (pop) begin
      state_nxt = SCHED_SERVE;
    end else if (!any_elig) begin
      state_nxt = SCHED_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SCHED_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Any pick not continuing a burst (new queue, or the sole eligible queue re-picked) restarts the count at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      grant     <= IDX_WIDTH'(N_QUEUES - 1);
      burst_cnt <= '0;
    end else if (pop) begin
      out_data  <= q_word[pick];
      out_src   <= pick;
      out_valid <= 1'b1;
      grant     <= pick;
      burst_cnt <= cont_burst ? burst_cnt + 1'b1 : BURST_WIDTH'(1);
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (!any_elig) begin
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Scoreboard bench for fifo_rr_scheduler: behavioural queue models feed the DUT, a monitor checks each accepted beat.
module tb_fifo_rr_scheduler;

  localparam int unsigned NQ = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NQ-1:0]      q_empty;
  logic [NQ*DW-1:0]   q_dout;
  logic [NQ-1:0]      q_rd_en;
  logic [NQ-1:0]      cfg_enable;
  logic [DW-1:0]      out_data;
  logic [IW-1:0]      out_src;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  always #5 clk = ~clk;

  fifo_rr_scheduler #(
    .N_QUEUES  (NQ),
    .DWIDTH    (DW),
    .BURST_MAX (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .q_empty    (q_empty),
    .q_dout     (q_dout),
    .q_rd_en    (q_rd_en),
    .cfg_enable (cfg_enable),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  // Queue models: pushes from stimulus, pops on q_rd_en at the clock edge, flushed by rst.
  logic [DW-1:0] mem [NQ][256];
  int unsigned   rd_ptr [NQ] = '{default: 0};
  int unsigned   wr_ptr [NQ] = '{default: 0};

  always_comb begin
    q_empty = '0;
    q_dout  = '0;
    for (int i = 0; i < NQ; i++) begin
      q_empty[i]         = (rd_ptr[i] == wr_ptr[i]);
      q_dout[i*DW +: DW] = mem[i][8'(rd_ptr[i])];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NQ; i++) begin
      if (rst) rd_ptr[i] <= wr_ptr[i];
      else if (q_rd_en[i]) rd_ptr[i] <= rd_ptr[i] + 1;
    end
  end

  typedef struct packed {
    logic [IW-1:0] src;
    logic [DW-1:0] data;
  } beat_t;

  beat_t       expq[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      chk("rd_en_in_rst", 32'(q_rd_en), 0);
    end else begin
      if (q_rd_en != '0) begin
        chk("rd_en_onehot", 32'($onehot(q_rd_en)), 1);
        chk("rd_en_eligible", 32'(q_rd_en & ~(~q_empty & cfg_enable)), 0);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_beat", 32'({out_src, out_data}), 32'hFFFF_FFFF);
        end else begin
          beat_t e;
          e = expq.pop_front();
          chk("beat_src", 32'(out_src), 32'(e.src));
          chk("beat_data", 32'(out_data), 32'(e.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input int unsigned q, input logic [DW-1:0] d);
    mem[q][8'(wr_ptr[q])] = d;
    wr_ptr[q] = wr_ptr[q] + 1;
  endtask

  task automatic exp_beat(input int unsigned q, input logic [DW-1:0] d);
    beat_t b;
    b.src  = IW'(q);
    b.data = d;
    expq.push_back(b);
  endtask

  // Counts negedges until every expected beat has been consumed.
  task automatic drain(input int unsigned budget, input int unsigned exp_n, input string name);
    int unsigned n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (expq.size() != 0) begin
      chk({name, "_timeout"}, 32'(expq.size()), 0);
      expq.delete();
    end else begin
      chk(name, n, exp_n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    out_ready  = 1'b1;
    cfg_enable = '1;

    // Reset state
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_src", 32'(out_src), 0);
    chk("rst_rd_en", 32'(q_rd_en), 0);
    chk("rst_busy", 32'(busy), 0);

    // Test 1: single queue, three words
    for (int j = 0; j < 3; j++) begin
      load(0, 16'hA000 + 16'(j));
      exp_beat(0, 16'hA000 + 16'(j));
    end
    drain(50, 4, "t1_cycles");
    tick();
    chk("t1_valid_end", 32'(out_valid), 0);
    chk("t1_busy_end", 32'(busy), 0);

    // Test 2: all queues with 6 words, burst of 4 then remainder
    do_reset();
    for (int q = 0; q < 4; q++)
      for (int j = 0; j < 6; j++)
        load(q, 16'hB000 + 16'(q * 256 + j));
    for (int q = 0; q < 4; q++)
      for (int j = 0; j < 4; j++)
        exp_beat(q, 16'hB000 + 16'(q * 256 + j));
    for (int q = 0; q < 4; q++)
      for (int j = 4; j < 6; j++)
        exp_beat(q, 16'hB000 + 16'(q * 256 + j));
    drain(100, 25, "t2_cycles");

    // Test 3: backpressure hold and same-cycle resume
    do_reset();
    for (int j = 0; j < 4; j++) begin
      load(1, 16'hC100 + 16'(j));
      exp_beat(1, 16'hC100 + 16'(j));
    end
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_valid", 32'(out_valid), 1);
      chk("t3_hold_data", 32'(out_data), 32'h0000_C100);
      chk("t3_hold_src", 32'(out_src), 1);
      chk("t3_hold_rd_en", 32'(q_rd_en), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_resume_rd_en", 32'(q_rd_en), 32'b0010);
    drain(20, 4, "t3_cycles");

    // Test 4: sole eligible queue, burst rollover without bubble
    do_reset();
    for (int j = 0; j < 10; j++) begin
      load(2, 16'hD200 + 16'(j));
      exp_beat(2, 16'hD200 + 16'(j));
    end
    drain(50, 11, "t4_cycles");

    // Test 5: enable dropped mid-burst, then restored
    do_reset();
    for (int j = 0; j < 4; j++) begin
      load(1, 16'hE100 + 16'(j));
      load(2, 16'hE200 + 16'(j));
    end
    exp_beat(1, 16'hE100);
    exp_beat(1, 16'hE101);
    exp_beat(2, 16'hE200);
    exp_beat(2, 16'hE201);
    exp_beat(2, 16'hE202);
    exp_beat(2, 16'hE203);
    exp_beat(1, 16'hE102);
    exp_beat(1, 16'hE103);
    tick();
    tick();
    cfg_enable = 4'b1101;
    #1;
    chk("t5_skip_q1", 32'(q_rd_en), 32'b0100);
    tick();
    tick();
    cfg_enable = 4'b1111;
    drain(50, 5, "t5_cycles");

    // Test 6: reset mid-stream discards the in-flight beat
    do_reset();
    for (int j = 0; j < 6; j++) load(3, 16'hF300 + 16'(j));
    exp_beat(3, 16'hF300);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t6_rd_en_in_rst", 32'(q_rd_en), 0);
    tick();
    rst = 1'b0;
    chk("t6_valid_after_rst", 32'(out_valid), 0);
    for (int q = 0; q < 4; q++) begin
      load(q, 16'h6000 + 16'(q * 256));
      exp_beat(q, 16'h6000 + 16'(q * 256));
    end
    #1;
    chk("t6_first_pick", 32'(q_rd_en), 32'b0001);
    drain(30, 5, "t6_cycles");

    tick();
    chk("end_busy", 32'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
